// File: rtl/boot_pkg.sv
// Shared types and constants for the bootloader sequencer.
// Frame layout: two length bytes, then 4-byte little-endian words, then a checksum byte.
package boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } boot_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Packs payload bytes, least-significant byte first, into 32-bit words.
// word is valid in the same cycle as the last byte of each word.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  byte_idx,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] partial;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial <= '0;
        end else if (byte_valid) begin
            partial <= {byte_data, partial[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, partial};

endmodule

// File: rtl/boot_load_ctrl.sv
// Bootloader sequencer: drains the receive byte queue, writes the payload into
// instruction memory and releases the CPU only after a good checksum.
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              q_empty,
    input  logic [7:0]        q_data,
    output logic              q_remove,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    boot_state_t state, state_next;

    logic [7:0]               acc;
    logic [7:0]               len_lo;
    logic [8*LEN_BYTES-1:0]   len_q;
    logic [8*LEN_BYTES-1:0]   len_full;
    logic [1:0]               byte_idx;
    logic [ADDR_W:0]          word_cnt;
    logic                     busy_state;
    logic                     pop;
    logic                     take_start;
    logic                     data_byte;
    logic                     last_word;
    logic [31:0]              word;
    logic                     word_valid;

    assign len_full  = {q_data, len_lo};
    assign data_byte = pop && (state == S_DATA);
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len_q);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (data_byte),
        .byte_data  (q_data),
        .byte_idx   (byte_idx),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        take_start = 1'b0;
        busy_state = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
        pop        = busy_state && !q_empty;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    take_start = 1'b1;
                    state_next = S_LEN0;
                end
            end
            S_LEN0: if (pop) state_next = S_LEN1;
            S_LEN1: begin
                if (pop) begin
                    if (32'(len_full) > (32'd1 << ADDR_W)) state_next = S_ERR;
                    else if (len_full == '0)                state_next = S_CSUM;
                    else                                    state_next = S_DATA;
                end
            end
            S_DATA: if (word_valid && last_word) state_next = S_CSUM;
            S_CSUM: if (pop) state_next = (q_data == acc) ? S_DONE : S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    assign q_remove = pop;
    assign busy     = busy_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            len_lo    <= '0;
            len_q     <= '0;
            byte_idx  <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            mem_we <= word_valid;
            if (word_valid) begin
                mem_addr  <= ADDR_W'(32'(BASE_ADDR) + 32'(word_cnt));
                mem_wdata <= word;
                word_cnt  <= word_cnt + (ADDR_W+1)'(1);
            end
            if (take_start) begin
                acc      <= '0;
                byte_idx <= '0;
                word_cnt <= '0;
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end
            // The checksum byte itself is compared, not accumulated.
            if (pop && state != S_CSUM)  acc      <= acc + q_data;
            if (pop && state == S_LEN0)  len_lo   <= q_data;
            if (pop && state == S_LEN1)  len_q    <= len_full;
            if (data_byte)               byte_idx <= byte_idx + 2'd1;
            if (state == S_CSUM && state_next == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (state != S_ERR && state_next == S_ERR) err <= 1'b1;
        end
    end

endmodule
